// File: rtl/rr_burst_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_burst_arbiter
//  Description : Round-robin burst arbiter. Shares one downstream valid/ready
//                port between NUM_REQ requesters. The owner keeps the port
//                until it marks a beat last or the hold limit forces it; the
//                grant then rotates to the next requester in order.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_burst_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int DATA_W   = 32,
    parameter int MAX_HOLD = 8,
    localparam int ID_W    = $clog2(NUM_REQ),
    localparam int CNT_W   = $clog2(MAX_HOLD + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    input  logic [NUM_REQ-1:0]        req_last,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      out_valid,
    output logic [DATA_W-1:0]         out_data,
    output logic                      out_last,
    input  logic                      out_ready,
    output logic [NUM_REQ-1:0]        grant,
    output logic [ID_W-1:0]           grant_id,
    output logic                      busy
);

    // Beat index that is forced to close the burst.
    localparam logic [CNT_W-1:0] C_LAST_BEAT = CNT_W'(MAX_HOLD - 1);
    // Highest requester index; the round-robin pointer wraps after it.
    localparam logic [ID_W-1:0]  C_LAST_ID   = ID_W'(NUM_REQ - 1);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [NUM_REQ-1:0] r_grant;
    logic [NUM_REQ-1:0] w_grant_nxt;
    logic [ID_W-1:0]    r_grant_id;
    logic [ID_W-1:0]    w_grant_id_nxt;
    logic [ID_W-1:0]    r_rr_ptr;
    logic [ID_W-1:0]    w_rr_ptr_nxt;
    logic [CNT_W-1:0]   r_beat_cnt;
    logic [CNT_W-1:0]   w_beat_cnt_nxt;

    logic               w_pick_found;
    logic [ID_W-1:0]    w_pick_id;
    logic [DATA_W-1:0]  w_lane_data [NUM_REQ];
    logic [DATA_W-1:0]  w_sel_data;
    logic               w_sel_valid;
    logic               w_sel_last;
    logic               w_in_grant;
    logic               w_xfer;

    // Split the flat payload bus into one word per requester.
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_lane
            assign w_lane_data[gi] = req_data[gi*DATA_W +: DATA_W];
            // Only the owner's ready follows the downstream accept.
            assign req_ready[gi]   = r_grant[gi] & out_ready;
        end
    endgenerate

    // Rotating-priority pick: first scan indices at or above the pointer,
    // then wrap around to the indices below it.
    always_comb begin
        w_pick_found = 1'b0;
        w_pick_id    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!w_pick_found && req_valid[i] && (ID_W'(i) >= r_rr_ptr)) begin
                w_pick_found = 1'b1;
                w_pick_id    = ID_W'(i);
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!w_pick_found && req_valid[i]) begin
                w_pick_found = 1'b1;
                w_pick_id    = ID_W'(i);
            end
        end
    end

    // Owner lane selection for the forwarded handshake signals.
    always_comb begin
        w_sel_data  = w_lane_data[r_grant_id];
        w_sel_valid = req_valid[r_grant_id];
        w_sel_last  = req_last[r_grant_id];
    end

    assign w_in_grant = (r_state == S_GRANT);
    assign out_valid  = w_in_grant & w_sel_valid;
    assign out_last   = w_in_grant & (w_sel_last | (r_beat_cnt == C_LAST_BEAT));
    assign out_data   = w_in_grant ? w_sel_data : '0;
    assign w_xfer     = out_valid & out_ready;

    assign grant      = r_grant;
    assign grant_id   = r_grant_id;
    assign busy       = w_in_grant;

    // Next-state logic: arbitrate in IDLE, count beats and release in GRANT.
    always_comb begin
        w_state_nxt    = r_state;
        w_grant_nxt    = r_grant;
        w_grant_id_nxt = r_grant_id;
        w_rr_ptr_nxt   = r_rr_ptr;
        w_beat_cnt_nxt = r_beat_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_pick_found) begin
                    w_state_nxt    = S_GRANT;
                    w_grant_nxt    = NUM_REQ'(1) << w_pick_id;
                    w_grant_id_nxt = w_pick_id;
                    w_beat_cnt_nxt = '0;
                end
            end
            S_GRANT: begin
                if (w_xfer) begin
                    if (out_last) begin
                        // Release: pointer moves past the owner so everyone
                        // else is considered before it again.
                        w_state_nxt    = S_IDLE;
                        w_grant_nxt    = '0;
                        w_beat_cnt_nxt = '0;
                        w_rr_ptr_nxt   = (r_grant_id == C_LAST_ID) ? '0
                                                                   : r_grant_id + ID_W'(1);
                    end else begin
                        w_beat_cnt_nxt = r_beat_cnt + CNT_W'(1);
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_grant_nxt = '0;
            end
        endcase
    end

    // State and arbitration registers; reset abandons any partial burst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_grant    <= '0;
            r_grant_id <= '0;
            r_rr_ptr   <= '0;
            r_beat_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_grant    <= w_grant_nxt;
            r_grant_id <= w_grant_id_nxt;
            r_rr_ptr   <= w_rr_ptr_nxt;
            r_beat_cnt <= w_beat_cnt_nxt;
        end
    end

`ifndef SYNTHESIS
    // Grant is one-hot while owned and empty while idle.
    a_grant_onehot : assert property (@(posedge clk) disable iff (rst)
        $onehot0(r_grant));
    a_busy_grant   : assert property (@(posedge clk) disable iff (rst)
        busy == (r_grant != '0));
    a_grant_match  : assert property (@(posedge clk) disable iff (rst)
        busy |-> r_grant[r_grant_id]);
    a_id_range     : assert property (@(posedge clk) disable iff (rst)
        (r_grant_id <= C_LAST_ID) && (r_rr_ptr <= C_LAST_ID));
    a_cnt_range    : assert property (@(posedge clk) disable iff (rst)
        r_beat_cnt < CNT_W'(MAX_HOLD));
`endif

endmodule
`default_nettype wire

// File: tb/tb_rr_burst_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rr_burst_arbiter
//  Description : Self-checking bench for rr_burst_arbiter (4 requesters,
//                32-bit data, hold limit 8). Vector table plus directed
//                multi-cycle sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rr_burst_arbiter;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [3:0]   req_valid = '0;
    logic [127:0] req_data = '0;
    logic [3:0]   req_last = '0;
    logic [3:0]   req_ready;
    logic         out_valid;
    logic [31:0]  out_data;
    logic         out_last;
    logic         out_ready = 1'b0;
    logic [3:0]   grant;
    logic [1:0]   grant_id;
    logic         busy;

    int checks = 0;
    int errors = 0;

    rr_burst_arbiter #(
        .NUM_REQ  (4),
        .DATA_W   (32),
        .MAX_HOLD (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_ready (out_ready),
        .grant     (grant),
        .grant_id  (grant_id),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Lane i carries {i, 16'h0, tag} so a wrong lane select is visible.
    function automatic logic [31:0] lane_data(input int i, input logic [7:0] tag);
        return {8'(i), 16'h0000, tag};
    endfunction

    task automatic set_data(input logic [7:0] tag);
        for (int i = 0; i < 4; i++) req_data[i*32 +: 32] = lane_data(i, tag);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; req_valid = '0; req_last = '0; out_ready = 1'b0; set_data(8'h00);
        @(negedge clk);
        rst = 1'b0;
    endtask

    typedef struct {
        logic        rst;
        logic [3:0]  v;
        logic [3:0]  l;
        logic        r;
        logic [7:0]  tag;
        logic [3:0]  eg;
        logic [1:0]  eid;
        logic        eb;
        logic        ev;
        logic        el;
        logic [3:0]  er;
        logic [31:0] ed;
    } vec_t;

    vec_t tv [13];

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : main
        int          sent;
        int          cyc;
        int          nlast;
        logic        r3done;
        logic        prev_busy;
        logic        granted;
        logic        done;
        logic [1:0]  grants [$];
        logic [31:0] got [$];
        logic        pat [4];
        logic [1:0]  exp_order [3];

        // rst, valid, last, ready, tag | grant, id, busy, ovalid, olast, rdy, odata
        tv[0]  = '{1'b1, 4'hF, 4'hF, 1'b1, 8'h55, 4'h0, 2'd0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0};
        tv[1]  = '{1'b0, 4'h0, 4'h0, 1'b0, 8'h00, 4'h0, 2'd0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0};
        tv[2]  = '{1'b0, 4'h4, 4'h0, 1'b1, 8'hA0, 4'h0, 2'd0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0};
        tv[3]  = '{1'b0, 4'h4, 4'hB, 1'b1, 8'hA0, 4'h4, 2'd2, 1'b1, 1'b1, 1'b0, 4'h4, 32'h020000A0};
        tv[4]  = '{1'b0, 4'h4, 4'hB, 1'b1, 8'hA1, 4'h4, 2'd2, 1'b1, 1'b1, 1'b0, 4'h4, 32'h020000A1};
        tv[5]  = '{1'b0, 4'h4, 4'h4, 1'b1, 8'hA2, 4'h4, 2'd2, 1'b1, 1'b1, 1'b1, 4'h4, 32'h020000A2};
        tv[6]  = '{1'b0, 4'h0, 4'h0, 1'b1, 8'h00, 4'h0, 2'd2, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0};
        tv[7]  = '{1'b0, 4'h9, 4'h9, 1'b1, 8'hB0, 4'h0, 2'd2, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0};
        tv[8]  = '{1'b0, 4'h9, 4'h9, 1'b1, 8'hB0, 4'h8, 2'd3, 1'b1, 1'b1, 1'b1, 4'h8, 32'h030000B0};
        tv[9]  = '{1'b0, 4'h9, 4'h9, 1'b0, 8'hB1, 4'h0, 2'd3, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0};
        tv[10] = '{1'b0, 4'h9, 4'h9, 1'b0, 8'hB1, 4'h1, 2'd0, 1'b1, 1'b1, 1'b1, 4'h0, 32'h000000B1};
        tv[11] = '{1'b0, 4'h9, 4'h9, 1'b1, 8'hB2, 4'h1, 2'd0, 1'b1, 1'b1, 1'b1, 4'h1, 32'h000000B2};
        tv[12] = '{1'b0, 4'h0, 4'h0, 1'b1, 8'h00, 4'h0, 2'd0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0};

        // ---- Vector table: reset, single burst from req 2, pointer rotation
        for (int k = 0; k < 13; k++) begin
            @(negedge clk);
            rst = tv[k].rst; req_valid = tv[k].v; req_last = tv[k].l;
            out_ready = tv[k].r; set_data(tv[k].tag);
            #1;
            check($sformatf("v%0d grant", k),     32'(grant),     32'(tv[k].eg));
            check($sformatf("v%0d grant_id", k),  32'(grant_id),  32'(tv[k].eid));
            check($sformatf("v%0d busy", k),      32'(busy),      32'(tv[k].eb));
            check($sformatf("v%0d out_valid", k), 32'(out_valid), 32'(tv[k].ev));
            check($sformatf("v%0d out_last", k),  32'(out_last),  32'(tv[k].el));
            check($sformatf("v%0d req_ready", k), 32'(req_ready), 32'(tv[k].er));
            check($sformatf("v%0d out_data", k),  out_data,       tv[k].ed);
        end

        // ---- Fairness: all requesters send single-beat bursts
        do_reset();
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            req_valid = 4'hF; req_last = 4'hF; out_ready = 1'b1; set_data(8'(k));
            #1;
            check($sformatf("fair c%0d grant", k), 32'(grant),
                  (k % 2 == 1) ? (32'd1 << ((k / 2) % 4)) : 32'd0);
        end

        // ---- Hold limit: req 1 streams 20 beats, req 3 joins later
        do_reset();
        sent = 0; cyc = 0; nlast = 0; r3done = 1'b0; prev_busy = 1'b0;
        grants.delete();
        while (sent < 20 && cyc < 80) begin
            @(negedge clk);
            req_valid = {((cyc >= 3) && !r3done), 1'b0, 1'b1, 1'b0};
            req_last  = 4'b1000; out_ready = 1'b1; set_data(8'(sent));
            #1;
            if (busy && !prev_busy) grants.push_back(grant_id);
            prev_busy = busy;
            if (out_valid && grant[1]) begin
                check($sformatf("hold beat%0d data", sent), out_data, lane_data(1, 8'(sent)));
                check($sformatf("hold beat%0d last", sent), 32'(out_last),
                      32'((sent % 8) == 7));
                if (out_last) nlast++;
                sent++;
            end
            if (out_valid && grant[3]) r3done = 1'b1;
            cyc++;
        end
        check("hold beats sent", 32'(sent), 32'd20);
        check("hold forced lasts", 32'(nlast), 32'd2);
        check("hold grant count", 32'(grants.size() >= 3), 32'd1);
        exp_order = '{2'd1, 2'd3, 2'd1};
        for (int i = 0; i < 3; i++)
            check($sformatf("hold grant order %0d", i),
                  (i < grants.size()) ? 32'(grants[i]) : 32'hFF, 32'(exp_order[i]));

        // ---- Backpressure and valid gaps on req 0
        do_reset();
        pat = '{1'b1, 1'b0, 1'b0, 1'b1};
        sent = 0; cyc = 0; granted = 1'b0;
        got.delete();
        while (sent < 5 && cyc < 60) begin
            @(negedge clk);
            out_ready = pat[cyc % 4];
            req_valid = {3'b000, !(cyc == 4 || cyc == 5)};
            req_last  = {3'b000, sent == 4};
            set_data(8'(8'hC0 + sent));
            #1;
            if (busy) granted = 1'b1;
            if (granted) begin
                check($sformatf("bp c%0d grant", cyc), 32'(grant), 32'h1);
                check($sformatf("bp c%0d req_ready", cyc), 32'(req_ready), {31'd0, out_ready});
            end
            if (out_valid && out_ready) begin
                got.push_back(out_data);
                check($sformatf("bp beat%0d last", sent), 32'(out_last), 32'(sent == 4));
                sent++;
            end
            cyc++;
        end
        check("bp beat count", 32'(got.size()), 32'd5);
        for (int i = 0; i < 5; i++)
            check($sformatf("bp beat%0d data", i),
                  (i < got.size()) ? got[i] : 32'hDEADBEEF, lane_data(0, 8'(8'hC0 + i)));

        // ---- Async reset mid-burst
        do_reset();
        done = 1'b0;
        for (int k = 0; k < 10 && !done; k++) begin
            @(negedge clk);
            req_valid = 4'b0100; req_last = 4'b0100; out_ready = 1'b1; set_data(8'hE0);
            #1;
            if (out_valid && out_ready) done = 1'b1;
        end
        check("rst pre-burst req2", 32'(done), 32'd1);
        sent = 0; done = 1'b0;
        for (int k = 0; k < 20 && !done; k++) begin
            @(negedge clk);
            req_valid = 4'b0001; req_last = 4'b0000; out_ready = 1'b1; set_data(8'(8'hF0 + sent));
            #1;
            if (out_valid && grant[0]) begin
                if (sent == 2) begin
                    check("rst beat3 valid before", 32'(out_valid), 32'd1);
                    #2 rst = 1'b1;
                    #1;
                    check("rst out_valid", 32'(out_valid), 32'd0);
                    check("rst out_last",  32'(out_last),  32'd0);
                    check("rst out_data",  out_data,       32'd0);
                    check("rst grant",     32'(grant),     32'd0);
                    check("rst req_ready", 32'(req_ready), 32'd0);
                    check("rst busy",      32'(busy),      32'd0);
                    done = 1'b1;
                end
                sent++;
            end
        end
        check("rst reached beat3", 32'(done), 32'd1);
        @(negedge clk);
        rst = 1'b0; req_valid = 4'b1001; req_last = 4'b1001; out_ready = 1'b1; set_data(8'h11);
        #1;
        check("post-rst idle busy", 32'(busy), 32'd0);
        @(negedge clk);
        #1;
        check("post-rst grant", 32'(grant), 32'h1);
        check("post-rst grant_id", 32'(grant_id), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
